bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of the data bus and of each requester's data word.
REQ-002 Parameter MIN_VALID, default 2, earliest dValid cycle (1-based) on which dAck is accepted.
REQ-003 Parameter MAX_VALID, default 4, last dValid cycle before the transfer is forcibly ended.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  2  per-requester transfer request, level, held until the matching done.
REQ-007 req_data  input  2*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
REQ-008 dAck  input  1  target acknowledge, sampled on posedge.
REQ-009 dValid  output  1  registered bus valid.
REQ-010 data  output  DATA_W  registered bus data.
REQ-011 done  output  2  one-cycle pulse to requester i on acknowledged completion.
REQ-012 timeout  output  1  one-cycle pulse when a transfer ends without dAck.
REQ-013 early_ack  output  1  one-cycle pulse when dAck is high on dValid cycle 1.
REQ-014 xfer_cnt  output  16  completed-transfer count (see Configuration).
REQ-015 tmo_cnt  output  8  timeout count (see Configuration).

Function
REQ-016 States SHALL be IDLE, VALID and GAP; a cycle counter k (1..MAX_VALID) SHALL track dValid cycles in VALID.
REQ-017 IDLE: at a posedge with req nonzero, the SHALL select a winner, latch its req_data into data, set dValid, k=1, and go to VALID; dValid is high starting the cycle after that edge.
REQ-018 Arbitration SHALL be round-robin: with both req bits high, the requester not served last wins; after reset requester 0 has priority.
REQ-019 The last-served pointer SHALL update on every transfer start, whether it completes or times out.
REQ-020 data SHALL remain constant for the whole VALID period and while in GAP.
REQ-021 VALID, dAck high at a posedge with k>=MIN_VALID: the block SHALL go to GAP, clear dValid, and pulse done[winner] for the GAP cycle.
REQ-022 VALID, dAck high with k=1: the block SHALL ignore dAck for completion, pulse early_ack next cycle, and continue.
REQ-023 VALID, k=MAX_VALID with dAck low: the block SHALL go to GAP, clear dValid, pulse timeout; done is not asserted, and req remains pending for re-arbitration.
REQ-024 Otherwise in VALID, k SHALL increment and dValid stays high; dValid is therefore high for 2..4 consecutive cycles and low the cycle after the ack cycle.
REQ-025 GAP SHALL last exactly one cycle, then go to IDLE unconditionally; at least two low dValid cycles separate transfers.
REQ-026 dAck outside VALID SHALL be ignored with no flag.
REQ-027 A req deasserted during VALID SHALL NOT abort the transfer.

Reset
REQ-028 While reset is low, asynchronously: state=IDLE, k=0, dValid=0, data=0, done=0, timeout=0, early_ack=0, pointer=requester 0, xfer_cnt=0, tmo_cnt=0.
REQ-029 Reset asserted mid-transfer SHALL drop dValid immediately, with no done or timeout pulse for the aborted transfer.
REQ-030 After reset rises, the first arbitration SHALL occur at the first posedge in IDLE with req nonzero.

Configuration
REQ-031 Macro BUS_ARBITER_STATS_EN: when defined, xfer_cnt SHALL increment on every done pulse and tmo_cnt on every timeout pulse, both saturating at all-ones.
REQ-032 When BUS_ARBITER_STATS_EN is undefined, xfer_cnt and tmo_cnt SHALL be constant 0 and no counter registers are synthesized.

Verification
REQ-033 req=01, req_data[7:0]=8'hA5, dAck high on dValid cycle 2 -> dValid high 2 cycles, data=A5 throughout, done=01 one cycle, dValid low after.
REQ-034 req=11 held, dAck on cycle 3 each transfer -> grants alternate 0,1,0,1; at least two idle cycles between dValid pulses.
REQ-035 req=10, dAck never -> dValid high exactly 4 cycles, timeout pulse, done=00, transfer restarts for requester 1; tmo_cnt=1 with STATS_EN.
REQ-036 dAck high on cycle 1 then on cycle 2 -> early_ack pulse, completion on cycle 2, done pulse, xfer_cnt=1 with STATS_EN, 0 without.
REQ-037 reset low on dValid cycle 2 -> dValid, data, done are 0 immediately; after release with req=11, requester 0 wins.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin bus arbiter with a dValid/dAck transfer window
// Optional saturating transfer/timeout statistics are enabled by defining BUS_ARBITER_STATS_EN.
module bus_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MIN_VALID = 2,
    parameter int MAX_VALID = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [2*DATA_W-1:0] req_data,
    input  logic                dAck,
    output logic                dValid,
    output logic [DATA_W-1:0]   data,
    output logic [1:0]          done,
    output logic                timeout,
    output logic                early_ack,
    output logic [15:0]         xfer_cnt,
    output logic [7:0]          tmo_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VALID = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int K_W = $clog2(MAX_VALID + 1);
    localparam logic [K_W-1:0] K_ONE = K_W'(1);
    localparam logic [K_W-1:0] K_MIN = K_W'(MIN_VALID);
    localparam logic [K_W-1:0] K_MAX = K_W'(MAX_VALID);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [K_W-1:0]      r_k;
    logic [K_W-1:0]      w_k_nxt;
    logic                r_prio;
    logic                w_prio_nxt;
    logic                r_winner;
    logic                w_winner_nxt;
    logic                r_dvalid;
    logic                w_dvalid_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [1:0]          r_done;
    logic [1:0]          w_done_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;
    logic                r_early;
    logic                w_early_nxt;

    logic                w_start;
    logic                w_grant;
    logic                w_first;
    logic                w_accept;
    logic                w_expire;

    // r_prio names the requester that wins a tie; it flips away from every started transfer.
    assign w_start  = (r_state == S_IDLE) && (req != 2'b00);
    assign w_grant  = (req == 2'b11) ? r_prio : req[1];
    assign w_first  = (r_state == S_VALID) && (r_k == K_ONE);
    assign w_accept = (r_state == S_VALID) && dAck && !w_first && (r_k >= K_MIN);
    assign w_expire = (r_state == S_VALID) && !w_accept && (r_k == K_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_VALID;
            S_VALID: if (w_accept || w_expire) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_k_nxt       = r_k;
        w_prio_nxt    = r_prio;
        w_winner_nxt  = r_winner;
        w_dvalid_nxt  = r_dvalid;
        w_data_nxt    = r_data;
        w_done_nxt    = 2'b00;
        w_timeout_nxt = 1'b0;
        w_early_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_k_nxt      = K_ONE;
                    w_winner_nxt = w_grant;
                    w_prio_nxt   = ~w_grant;
                    w_dvalid_nxt = 1'b1;
                    w_data_nxt   = w_grant ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                end
            end
            S_VALID: begin
                w_early_nxt = w_first && dAck;
                if (w_accept) begin
                    w_k_nxt      = '0;
                    w_dvalid_nxt = 1'b0;
                    w_done_nxt   = r_winner ? 2'b10 : 2'b01;
                end else if (w_expire) begin
                    w_k_nxt       = '0;
                    w_dvalid_nxt  = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_k_nxt = r_k + K_ONE;
                end
            end
            default: begin
                w_k_nxt      = '0;
                w_dvalid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k       <= '0;
            r_prio    <= 1'b0;
            r_winner  <= 1'b0;
            r_dvalid  <= 1'b0;
            r_data    <= '0;
            r_done    <= 2'b00;
            r_timeout <= 1'b0;
            r_early   <= 1'b0;
        end else begin
            r_k       <= w_k_nxt;
            r_prio    <= w_prio_nxt;
            r_winner  <= w_winner_nxt;
            r_dvalid  <= w_dvalid_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_early   <= w_early_nxt;
        end
    end

    assign dValid    = r_dvalid;
    assign data      = r_data;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign early_ack = r_early;

`ifdef BUS_ARBITER_STATS_EN
    logic [15:0] r_xfer_cnt;
    logic [7:0]  r_tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xfer_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            if (w_accept && (r_xfer_cnt != 16'hFFFF)) r_xfer_cnt <= r_xfer_cnt + 16'd1;
            if (w_expire && (r_tmo_cnt != 8'hFF))     r_tmo_cnt  <= r_tmo_cnt + 8'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
    assign tmo_cnt  = r_tmo_cnt;
`else
    assign xfer_cnt = 16'd0;
    assign tmo_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scoreboard bench for bus_arbiter
module tb_bus_arbiter;

    localparam int DW = 8;
`ifdef BUS_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [2*DW-1:0] req_data;
    logic          dAck;
    logic          dValid;
    logic [DW-1:0] data;
    logic [1:0]    done;
    logic          timeout;
    logic          early_ack;
    logic [15:0]   xfer_cnt;
    logic [7:0]    tmo_cnt;

    int checks = 0;
    int errors = 0;
    int exp_xfer = 0;
    int exp_tmo = 0;

    typedef struct {
        logic [1:0]    done;
        logic [DW-1:0] data;
        int            len;
        logic          tmo;
    } exp_t;

    exp_t sb[$];

    bus_arbiter #(
        .DATA_W    (DW),
        .MIN_VALID (2),
        .MAX_VALID (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .dAck      (dAck),
        .dValid    (dValid),
        .data      (data),
        .done      (done),
        .timeout   (timeout),
        .early_ack (early_ack),
        .xfer_cnt  (xfer_cnt),
        .tmo_cnt   (tmo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] d, input logic [DW-1:0] dat, input int len, input logic tmo);
        exp_t e;
        e.done = d;
        e.data = dat;
        e.len  = len;
        e.tmo  = tmo;
        sb.push_back(e);
        if (tmo) exp_tmo++;
        else     exp_xfer++;
    endtask

    // Called at a negedge; returns at the negedge of the GAP cycle.
    task automatic do_xfer(input int ack_cycle, input bit early, input bit rel, input bit gap_chk);
        int w = 0;
        int n = 0;
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        while (!dValid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("start", {31'd0, dValid}, 32'd1);
        if (gap_chk) chk("gap_ge2", {31'd0, (w >= 2)}, 32'd1);
        while (dValid && n < 8) begin
            n++;
            chk("data_hold", {24'd0, data}, {24'd0, e.data});
            dAck = (n == ack_cycle) || (early && n == 1);
            @(negedge clk);
            dAck = 1'b0;
            chk("early_ack", {31'd0, early_ack}, {31'd0, (early && n == 1)});
        end
        chk("len", n, e.len);
        chk("done", {30'd0, done}, {30'd0, e.done});
        chk("timeout", {31'd0, timeout}, {31'd0, e.tmo});
        chk("gap_data", {24'd0, data}, {24'd0, e.data});
        if (rel) req = req & ~e.done;
    endtask

    initial begin
        int w;
        reset = 1'b0;
        req = 2'b00;
        req_data = '0;
        dAck = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dvalid", {31'd0, dValid}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_early", {31'd0, early_ack}, 32'd0);
        chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        chk("rst_tmo_cnt", {24'd0, tmo_cnt}, 32'd0);
        reset = 1'b1;

        dAck = 1'b1;
        repeat (3) @(negedge clk);
        dAck = 1'b0;
        @(negedge clk);
        chk("idle_ack_dvalid", {31'd0, dValid}, 32'd0);
        chk("idle_ack_done", {30'd0, done}, 32'd0);
        chk("idle_ack_early", {31'd0, early_ack}, 32'd0);
        chk("idle_ack_tmo", {31'd0, timeout}, 32'd0);

        req_data = {8'h00, 8'hA5};
        push_exp(2'b01, 8'hA5, 2, 1'b0);
        req = 2'b01;
        do_xfer(2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_done_pulse", {30'd0, done}, 32'd0);
        chk("post_dvalid", {31'd0, dValid}, 32'd0);

        // requester 0 was served last, so the alternation starts with requester 1
        req_data = {8'h22, 8'h11};
        push_exp(2'b10, 8'h22, 3, 1'b0);
        push_exp(2'b01, 8'h11, 3, 1'b0);
        push_exp(2'b10, 8'h22, 3, 1'b0);
        push_exp(2'b01, 8'h11, 3, 1'b0);
        req = 2'b11;
        for (int i = 0; i < 4; i++) do_xfer(3, 1'b0, 1'b0, (i > 0));
        req = 2'b00;

        req_data = {8'h3C, 8'h00};
        push_exp(2'b00, 8'h3C, 4, 1'b1);
        push_exp(2'b10, 8'h3C, 2, 1'b0);
        req = 2'b10;
        do_xfer(0, 1'b0, 1'b0, 1'b0);
        do_xfer(2, 1'b0, 1'b1, 1'b1);
        chk("tmo_cnt", {24'd0, tmo_cnt}, STATS ? exp_tmo : 0);

        req_data = {8'h00, 8'h5A};
        push_exp(2'b01, 8'h5A, 2, 1'b0);
        req = 2'b01;
        do_xfer(2, 1'b1, 1'b1, 1'b0);
        chk("xfer_cnt", {16'd0, xfer_cnt}, STATS ? exp_xfer : 0);

        req_data = {8'h77, 8'h66};
        req = 2'b01;
        w = 0;
        while (!dValid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("abort_start", {31'd0, dValid}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_dvalid", {31'd0, dValid}, 32'd0);
        chk("abort_data", {24'd0, data}, 32'd0);
        chk("abort_done", {30'd0, done}, 32'd0);
        chk("abort_tmo", {31'd0, timeout}, 32'd0);
        chk("abort_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        exp_xfer = 0;
        exp_tmo = 0;
        req = 2'b11;
        @(negedge clk);
        reset = 1'b1;
        push_exp(2'b01, 8'h66, 2, 1'b0);
        push_exp(2'b10, 8'h77, 3, 1'b0);
        do_xfer(2, 1'b0, 1'b1, 1'b0);
        do_xfer(3, 1'b0, 1'b1, 1'b1);
        chk("final_xfer_cnt", {16'd0, xfer_cnt}, STATS ? exp_xfer : 0);
        chk("final_tmo_cnt", {24'd0, tmo_cnt}, STATS ? exp_tmo : 0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
